// File: rtl/sdram_pkg.sv
// Shared SDRAM tester definitions: address/data geometry, FSM states and the test pattern.
package sdram_pkg;

    localparam int unsigned BANK_W = 2;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PAT_W  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_HOLD = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    // Unseeded pattern word: low address byte followed by its complement.
    function automatic logic [PAT_W-1:0] pattern(input logic [7:0] a);
        return {a, ~a};
    endfunction

endpackage

// File: rtl/sdram_tester.sv
// Write-then-read-back SDRAM memory tester over a client request/ack interface.
module sdram_tester
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 24,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TEST_WORDS     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr,
    output logic                  timeout,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic [ADDR_BITS-1:0]  sdram_addr,
    output logic                  sdram_rh_wl,
    output logic [DATA_WIDTH-1:0] sdram_data_w,
    input  logic [DATA_WIDTH-1:0] sdram_data_r,
    input  logic                  sdram_data_r_en
);

    localparam int unsigned         TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TEST_WORDS - 1);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  seed_q;
    logic [1:0]             hold_cnt;
    logic [TO_W-1:0]        to_cnt;

    logic                   last_c;
    logic                   to_hit_c;
    logic [ADDR_BITS-1:0]   next_addr_c;
    logic [DATA_WIDTH-1:0]  pat_cur_c;
    logic [DATA_WIDTH-1:0]  pat_next_c;
    logic [DATA_WIDTH-1:0]  pat_start_c;
    logic                   mismatch_c;
    logic [15:0]            err_inc_c;

    // Address/pattern helpers shared by the write and read phases.
    always_comb begin
        last_c      = (sdram_addr == LAST_ADDR);
        to_hit_c    = (to_cnt == TO_LAST);
        next_addr_c = sdram_addr + ADDR_BITS'(1);
        pat_cur_c   = DATA_WIDTH'(pattern(8'(sdram_addr))) ^ seed_q;
        pat_next_c  = DATA_WIDTH'(pattern(8'(next_addr_c))) ^ seed_q;
        pat_start_c = DATA_WIDTH'(pattern(8'h00)) ^ seed;
        mismatch_c  = (sdram_data_r != pat_cur_c);
        err_inc_c   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state          <= IDLE;
            seed_q         <= '0;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            sdram_req      <= 1'b0;
            sdram_addr     <= '0;
            sdram_rh_wl    <= 1'b0;
            sdram_data_w   <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state          <= WR_REQ;
                        seed_q         <= seed;
                        hold_cnt       <= '0;
                        to_cnt         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        sdram_req      <= 1'b1;
                        sdram_addr     <= '0;
                        sdram_rh_wl    <= 1'b0;
                        sdram_data_w   <= pat_start_c;
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (sdram_ack) begin
                        state     <= (state == WR_REQ) ? WR_HOLD : RD_WAIT;
                        sdram_req <= 1'b0;
                        hold_cnt  <= '0;
                        to_cnt    <= '0;
                    end else if (to_hit_c) begin
                        state     <= FIN;
                        sdram_req <= 1'b0;
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // Address and write data stay put for four cycles after the ack.
                WR_HOLD: begin
                    if (hold_cnt == 2'd3) begin
                        state     <= last_c ? RD_REQ : WR_REQ;
                        sdram_req <= 1'b1;
                        to_cnt    <= '0;
                        if (last_c) begin
                            sdram_addr  <= '0;
                            sdram_rh_wl <= 1'b1;
                        end else begin
                            sdram_addr   <= next_addr_c;
                            sdram_data_w <= pat_next_c;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end

                RD_WAIT: begin
                    if (sdram_data_r_en) begin
                        to_cnt <= '0;
                        if (mismatch_c) begin
                            err_count <= err_inc_c;
                            if (err_count == 16'd0) first_err_addr <= sdram_addr;
                        end
                        if (last_c) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch_c && (err_count == 16'd0) && !timeout;
                        end else begin
                            state      <= RD_REQ;
                            sdram_req  <= 1'b1;
                            sdram_addr <= next_addr_c;
                        end
                    end else if (to_hit_c) begin
                        state   <= FIN;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    sdram_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_tester.sv
// Directed bench for sdram_tester with a behavioural request/ack SDRAM controller model.
module tb_sdram_tester;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          sdram_req, sdram_ack, sdram_rh_wl, sdram_data_r_en;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data_w, sdram_data_r;

    sdram_tester #(
        .ADDR_BITS(AW), .DATA_WIDTH(DW), .TEST_WORDS(8), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .reset_l(reset_l), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .timeout(timeout),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w),
        .sdram_data_r(sdram_data_r), .sdram_data_r_en(sdram_data_r_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model knobs and statistics.
    bit          m_corrupt5 = 0;
    bit          m_block_wr3 = 0;
    bit          m_stall = 0;
    int          n_req, n_ack, n_wr, n_rd, wr_bad, stab_err, extra_req, t0;
    logic [15:0] mem [0:7];

    bit          req_prev = 0, acked = 0, rd_pending = 0;
    int          wait_cnt = 0, hold_cnt = 0, rd_cnt = 0;
    logic [AW-1:0] req_addr, rd_addr;
    logic [DW-1:0] req_data;

    function automatic logic [DW-1:0] exp_pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
        logic [7:0] b;
        b = a[7:0];
        return {b, ~b} ^ s;
    endfunction

    // Model runs on the falling edge so its outputs are settled for the next rising edge.
    always @(negedge clk) begin
        sdram_ack       = 1'b0;
        sdram_data_r_en = 1'b0;
        if (start && !busy) begin
            n_req = 0; n_ack = 0; n_wr = 0; n_rd = 0; wr_bad = 0;
            stab_err = 0; extra_req = 0; t0 = 0;
        end
        if (!reset_l) begin
            req_prev = 0; acked = 0; rd_pending = 0; hold_cnt = 0; wait_cnt = 0;
        end else begin
            if (sdram_req && !req_prev) begin
                n_req++;
                req_addr = sdram_addr;
                req_data = sdram_data_w;
                wait_cnt = 0;
                acked    = 0;
                if (!sdram_rh_wl && sdram_addr == 24'd2) t0 = cyc;
            end
            if (sdram_req && acked) extra_req++;
            if (sdram_req && !acked) begin
                if (sdram_addr != req_addr || (!sdram_rh_wl && sdram_data_w != req_data))
                    stab_err++;
                wait_cnt++;
                if (wait_cnt == (m_stall ? 14 : 2) &&
                    !(m_block_wr3 && !sdram_rh_wl && sdram_addr == 24'd2)) begin
                    sdram_ack = 1'b1;
                    acked     = 1;
                    n_ack++;
                    if (!sdram_rh_wl) begin
                        n_wr++;
                        mem[sdram_addr[2:0]] = sdram_data_w;
                        if (sdram_data_w != exp_pat(sdram_addr, seed)) wr_bad++;
                        hold_cnt = 4;
                    end else begin
                        rd_pending = 1;
                        rd_cnt     = 0;
                        rd_addr    = sdram_addr;
                    end
                end
            end else if (hold_cnt > 0) begin
                if (sdram_addr != req_addr || sdram_data_w != req_data) stab_err++;
                hold_cnt--;
            end
            if (rd_pending) begin
                rd_cnt++;
                if (rd_cnt == 4) begin
                    rd_pending      = 0;
                    sdram_data_r_en = 1'b1;
                    sdram_data_r    = mem[rd_addr[2:0]];
                    if (m_corrupt5 && rd_addr == 24'd5) sdram_data_r[0] = ~sdram_data_r[0];
                    n_rd++;
                end
            end
            req_prev = sdram_req;
        end
    end

    task automatic pulse_start(input logic [DW-1:0] s);
        @(posedge clk); #1;
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},  32'(busy), 32'd0);
        check({pfx, "_done"},  32'(done), 32'd0);
        check({pfx, "_pass"},  32'(pass), 32'd0);
        check({pfx, "_errc"},  32'(err_count), 32'd0);
        check({pfx, "_ferr"},  32'(first_err_addr), 32'd0);
        check({pfx, "_tout"},  32'(timeout), 32'd0);
        check({pfx, "_req"},   32'(sdram_req), 32'd0);
        check({pfx, "_rhwl"},  32'(sdram_rh_wl), 32'd0);
        check({pfx, "_addr"},  32'(sdram_addr), 32'd0);
        check({pfx, "_dataw"}, 32'(sdram_data_w), 32'd0);
    endtask

    initial begin
        int t1;
        int req_hi;
        bit found;
        reset_l = 1'b0;
        start   = 1'b0;
        seed    = '0;
        sdram_ack = 1'b0;
        sdram_data_r_en = 1'b0;
        sdram_data_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk); reset_l = 1'b1;
        repeat (2) @(posedge clk);

        // Clean run, seed 0.
        pulse_start(16'h0000);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 500);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_errc", 32'(err_count), 32'd0);
        check("t1_nwr", 32'(n_wr), 32'd8);
        check("t1_nrd", 32'(n_rd), 32'd8);
        check("t1_wrbad", 32'(wr_bad), 32'd0);
        check("t1_mem5", 32'(mem[5]), 32'h05FA);
        check("t1_mem7", 32'(mem[7]), 32'h07F8);
        check("t1_mem0", 32'(mem[0]), 32'h00FF);

        // Corrupted read at address 5.
        m_corrupt5 = 1;
        pulse_start(16'h0000);
        wait_done("t2_done", 500);
        check("t2_errc", 32'(err_count), 32'd1);
        check("t2_ferr", 32'(first_err_addr), 32'd5);
        check("t2_pass", 32'(pass), 32'd0);
        m_corrupt5 = 0;

        // Third write never acknowledged.
        m_block_wr3 = 1;
        pulse_start(16'h0000);
        t1 = -1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (timeout) begin t1 = cyc; break; end
        end
        check("t3_tout", 32'(timeout), 32'd1);
        check("t3_latency", 32'(t1 - t0), 32'd1000);
        check("t3_done", 32'(done), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_req", 32'(sdram_req), 32'd0);
        check("t3_nwr", 32'(n_wr), 32'd2);
        m_block_wr3 = 0;

        // Refresh stalls, non-zero seed.
        m_stall = 1;
        pulse_start(16'hA5A5);
        check("t4_tout_clr", 32'(timeout), 32'd0);
        wait_done("t4_done", 2000);
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_reqack", 32'(n_req), 32'(n_ack));
        check("t4_nack", 32'(n_ack), 32'd16);
        check("t4_extra", 32'(extra_req), 32'd0);
        check("t4_stable", 32'(stab_err), 32'd0);
        check("t4_wrbad", 32'(wr_bad), 32'd0);
        check("t4_mem5", 32'(mem[5]), 32'hA05F);
        m_stall = 0;

        // Start while busy is ignored; reset mid-read aborts.
        pulse_start(16'h0000);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (busy && !sdram_req && !sdram_rh_wl && sdram_addr == 24'd3) begin found = 1; break; end
        end
        check("t5_hold3", 32'(found), 32'd1);
        seed  = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_addr_kept", 32'(sdram_addr), 32'd3);
        check("t5_data_kept", 32'(sdram_data_w), 32'h03FC);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (sdram_req && sdram_rh_wl && sdram_addr == 24'd3) begin found = 1; break; end
        end
        check("t5_rd3", 32'(found), 32'd1);
        #2 reset_l = 1'b0;
        #1;
        check_reset_outputs("t5rst");
        repeat (3) @(posedge clk);
        @(negedge clk) reset_l = 1'b1;
        req_hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (sdram_req || busy || done) req_hi++;
        end
        check("t5_quiet", 32'(req_hi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
